instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC0_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  decode not ready; if_valid/if_pc/if_instruction SHALL hold while stall=1.
REQ-005 branch_taken  input  1  redirect request from the EX-stage branch unit.
REQ-006 branch_address  input  32  redirect target; valid when branch_taken=1.
REQ-007 exception_taken  input  1  exception redirect; SHALL take priority over branch_taken.
REQ-008 exception_address  input  32  exception handler target.
REQ-009 inst_req  output  1  fetch request to instruction memory.
REQ-010 inst_addr  output  32  fetch address; SHALL be stable while inst_req=1 and inst_ack=0, except on a redirect.
REQ-011 inst_ack  input  1  memory accepts the request in any cycle where inst_req=1 and inst_ack=1.
REQ-012 inst_rvalid  input  1  read data return; one return per accepted request, in order, no backpressure.
REQ-013 inst_rdata  input  32  returned instruction word.
REQ-014 if_valid  output  1  if_pc/if_instruction hold a valid instruction for decode.
REQ-015 if_pc  output  32  address of the delivered instruction.
REQ-016 if_instruction  output  32  delivered instruction word.

Function
REQ-017 Fetch FSM SHALL have states IDLE, REQ and WAIT; at most one request SHALL be outstanding.
REQ-018 IDLE->REQ when buffer occupancy plus outstanding requests is below 2; REQ->WAIT on acceptance; WAIT->REQ or IDLE on inst_rvalid.
REQ-019 fetch_pc SHALL drive inst_addr and SHALL advance by 4, with 32-bit wrap, on each accepted request.
REQ-020 The block SHALL hold a 2-entry FIFO: an output register driving if_* plus one skid entry, in program order.
REQ-021 A non-discarded return SHALL be visible on if_* the cycle after inst_rvalid when the output register is empty or draining; otherwise it SHALL enter the skid entry.
REQ-022 A delivered instruction SHALL be consumed on any cycle with if_valid=1 and stall=0; the skid entry, or a same-cycle return, SHALL refill the output register.
REQ-023 Redirect = exception_taken or branch_taken; target = exception_address if exception_taken, else branch_address.
REQ-024 On redirect: fetch_pc<=target; output register and skid entry SHALL be flushed (if_valid=0 next cycle) regardless of stall.
REQ-025 Redirect in REQ without same-cycle ack: the pending request SHALL be withdrawn; the next cycle SHALL request target.
REQ-026 Redirect in REQ with same-cycle ack, or in WAIT without inst_rvalid: a discard flag SHALL be set and the next return SHALL be dropped.
REQ-027 Redirect in WAIT coincident with inst_rvalid: that data SHALL be dropped, no discard flag set, FSM->REQ with target.
REQ-028 Redirect while discard set: target SHALL update; the flag SHALL remain until one return is dropped.
REQ-029 Delay slot: EX SHALL assert a redirect only after the delay-slot instruction has left if_* (consumed by decode); the branch unit guarantees this.
REQ-030 Steady state without stall at 1-cycle ack and 1-cycle return latency SHALL sustain one instruction per 2 cycles.

Reset
REQ-031 While rst=1: inst_req=0, inst_addr=RESET_PC, if_valid=0, if_pc=0, if_instruction=0, FSM=IDLE, FIFO empty, discard=0.
REQ-032 First cycle after rst deasserts: FSM=REQ, inst_req=1, inst_addr=RESET_PC.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request; a stale inst_rvalid after reset SHALL be ignored until the first new request is accepted.

Verification
REQ-034 Reset release, ack/rvalid each 1 cycle, rdata=0x24020001 -> if_valid=1, if_pc=BFC00000, if_instruction=0x24020001; next inst_addr=BFC00004.
REQ-035 stall=1 held 5 cycles after first delivery -> if_* unchanged; at most one more return accepted into skid; no request issued while FIFO full.
REQ-036 branch_taken=1, branch_address=0x80001000 while in WAIT -> returning word dropped; next inst_addr=0x80001000; next if_pc=0x80001000.
REQ-037 branch_taken and exception_taken in same cycle (0x80001000 / 0x80000180) -> next fetch 0x80000180.
REQ-038 Redirect coincident with inst_rvalid -> data not delivered; inst_req=1 to target the following cycle; no later return dropped.
REQ-039 rst pulsed while in WAIT, stale inst_rvalid one cycle after release -> if_valid stays 0; inst_addr=BFC00000.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding fetch FSM feeding a 2-entry
// (output register + skid) instruction buffer, with branch/exception redirect.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    input  logic        exception_taken,
    input  logic [31:0] exception_address,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        discard_q, discard_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;

    logic        redirect;
    logic [31:0] target;
    logic        push;
    logic        consume;
    logic [1:0]  occ_q, occ_d;

    always_comb begin
        redirect = exception_taken | branch_taken;
        target   = exception_taken ? exception_address : branch_address;
        // Returns only count in WAIT; anything arriving in IDLE/REQ is stale.
        push     = (state_q == WAIT) && inst_rvalid && !discard_q && !redirect;
        consume  = out_valid_q && !stall;

        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_inst_d  = skid_inst_q;

        if (redirect) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pc_d     = skid_pc_q;
                out_inst_d   = skid_inst_q;
                skid_valid_d = push;
                if (push) begin
                    skid_pc_d   = req_pc_q;
                    skid_inst_d = inst_rdata;
                end
            end else begin
                out_valid_d = push;
                if (push) begin
                    out_pc_d   = req_pc_q;
                    out_inst_d = inst_rdata;
                end
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_inst_d  = inst_rdata;
        end

        occ_q = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
        occ_d = {1'b0, out_valid_d} + {1'b0, skid_valid_d};
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;

        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    state_d    = REQ;
                end else if (occ_q < 2'd2) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = target;
                    // An accepted request cannot be recalled; drop its data instead.
                    if (inst_ack) begin
                        discard_d = 1'b1;
                        state_d   = WAIT;
                    end
                end else if (inst_ack) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (inst_rvalid) begin
                    discard_d = 1'b0;
                    if (redirect) begin
                        fetch_pc_d = target;
                        state_d    = REQ;
                    end else begin
                        state_d = (occ_d < 2'd2) ? REQ : IDLE;
                    end
                end else if (redirect) begin
                    discard_d  = 1'b1;
                    fetch_pc_d = target;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= '0;
            discard_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_inst_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_inst_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_pc_q     <= req_pc_d;
            discard_q    <= discard_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_inst_q  <= skid_inst_d;
        end
    end

    assign inst_req       = (state_q == REQ);
    assign inst_addr      = fetch_pc_q;
    assign if_valid       = out_valid_q;
    assign if_pc          = out_pc_q;
    assign if_instruction = out_inst_q;

endmodule
